bus_master_port: RTL and testbench
==================================

BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 8, data width; MAX_RETRY, default 4, RETRY responses tolerated per command.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 cmd_valid  in  1  local command present.
REQ-005 cmd_ready  out  1  port accepts a command this cycle.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_lock  in  1  request a locked transfer.
REQ-008 cmd_addr  in  ADDR_W  target address.
REQ-009 cmd_wdata  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_err  out  1  completion status, qualified by rsp_valid: 1 = ERROR or retry limit.
REQ-012 rsp_rdata  out  DATA_W  read data, qualified by rsp_valid.
REQ-013 HREQ  out  1  bus request to the arbiter.
REQ-014 HLOCK  out  1  locked request to the arbiter.
REQ-015 HGRANT  in  1  grant from the arbiter.
REQ-016 HTRANS  out  1  address phase valid.
REQ-017 HADDR  out  ADDR_W  bus address.
REQ-018 HWRITE  out  1  bus direction.
REQ-019 HWDATA  out  DATA_W  bus write data.
REQ-020 HRDATA  in  DATA_W  bus read data.
REQ-021 HREADY  in  1  slave ready.
REQ-022 HRESP  in  2  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.

Function
REQ-023 The FSM SHALL have the states IDLE, REQ, ADDR and DATA.
REQ-024 In IDLE, cmd_ready SHALL be 1; on cmd_valid&cmd_ready the block SHALL register write, lock, addr and wdata, clear the retry count and enter REQ next cycle.
REQ-025 Outside IDLE, cmd_ready SHALL be 0 and the registered command SHALL remain unchanged.
REQ-026 In REQ, ADDR and DATA, HREQ SHALL be 1 and HLOCK SHALL equal the registered lock bit; in IDLE both SHALL be 0.
REQ-027 In REQ, HGRANT=1 SHALL move the FSM to ADDR the following cycle; otherwise it SHALL stay in REQ indefinitely.
REQ-028 ADDR SHALL last exactly one cycle, with HTRANS=1 and HADDR/HWRITE driven from the registered command; if HGRANT=0 in that cycle it SHALL return to REQ, else it SHALL go to DATA.
REQ-029 In DATA, HTRANS SHALL be 0, HADDR/HWRITE SHALL be held, and HWDATA SHALL carry the registered wdata (0 for reads); the FSM SHALL wait while HREADY=0, with no timeout.
REQ-030 DATA with HREADY=1 and HRESP=OKAY SHALL pulse rsp_valid with rsp_err=0 and go to IDLE; for reads, rsp_rdata SHALL capture HRDATA in that same cycle.
REQ-031 DATA with HREADY=1 and HRESP=ERROR SHALL pulse rsp_valid with rsp_err=1 and go to IDLE.
REQ-032 DATA with HREADY=1 and HRESP=RETRY SHALL increment the retry count; at count MAX_RETRY it SHALL complete as an error, otherwise it SHALL re-enter ADDR, keeping HREQ asserted.
REQ-033 A SPLIT response SHALL be acted on regardless of HREADY, sending the FSM to REQ without changing the retry count.
REQ-034 rsp_valid SHALL be 1 for exactly one cycle per accepted command.
REQ-035 Latency with an immediate grant and a zero-wait OKAY SHALL be 4 cycles from acceptance to rsp_valid.
REQ-036 A new command SHALL be accepted no earlier than the cycle after rsp_valid.
REQ-037 HGRANT dropping during DATA SHALL NOT abort the transfer.

Reset
REQ-038 With RST=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-transfer, and the pending command SHALL be discarded without a response.
REQ-039 Every output SHALL read 0 after reset, the registered command and retry count SHALL be 0, and cmd_ready SHALL rise in the first cycle after RST deasserts.

Structure
REQ-040 The shared package bus_pkg SHALL hold the HRESP encodings (OKAY, ERROR, RETRY, SPLIT) and the FSM state typedef, for reuse by the arbiter and slaves.
REQ-041 The block SHALL be one flat module with no sub-module; the retry counter SHALL be ceil(log2(MAX_RETRY+1)) bits wide.

Verification
REQ-042 Bench: write, addr 0x1234, data 0xA5, HGRANT immediate, HREADY=1, OKAY -> HREQ for 3 cycles, HADDR=0x1234, HWDATA=0xA5, rsp_valid 4 cycles after acceptance, rsp_err=0.
REQ-043 Bench: read with HGRANT delayed 5 cycles, 2 wait states, HRDATA=0x3C -> HTRANS one cycle after grant, rsp_rdata=0x3C, rsp_err=0.
REQ-044 Bench: RETRY answered 4 times (MAX_RETRY=4) -> 4 ADDR phases, then rsp_valid with rsp_err=1 and HREQ=0.
REQ-045 Bench: SPLIT in DATA, HGRANT held low 3 cycles then high, then OKAY -> HREQ held through the wait, a second ADDR phase, exactly one rsp_valid.
REQ-046 Bench: cmd_lock=1 -> HLOCK=1 from REQ through DATA; RST pulsed in DATA -> next cycle all outputs 0 and no rsp_valid.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: HRESP encodings and the master-port FSM state type,
// for reuse by the arbiter, slaves and masters.
package bus_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA
    } bus_state_t;

endpackage

// File: rtl/bus_master_port_if.sv
// Local command/response handshake plus arbitrated bus signals of one master port.
interface bus_master_port_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_lock;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              HREQ;
    logic              HLOCK;
    logic              HGRANT;
    logic              HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output HREQ, HLOCK, HTRANS, HADDR, HWRITE, HWDATA,
        input  HGRANT, HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  HREQ, HLOCK, HTRANS, HADDR, HWRITE, HWDATA,
        output HGRANT, HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/bus_master_port.sv
// Single-command bus master: requests the bus, runs one address/data transfer,
// handles RETRY/SPLIT responses and returns a registered one-cycle completion.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 4
) (
    input  logic              CLK,
    input  logic              RST,
    bus_master_port_if.master bus
);
    localparam int CNT_W = $clog2(MAX_RETRY + 1);

    bus_state_t        state_reg, state_next;
    logic              write_reg, write_next;
    logic              lock_reg, lock_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  retry_reg, retry_next;
    logic [CNT_W-1:0]  retry_inc;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              accept;

    // The completion pulse lands in IDLE, so acceptance is held off for that cycle.
    assign bus.cmd_ready = (state_reg == ST_IDLE) && !rsp_valid_reg && !RST;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign retry_inc     = retry_reg + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            write_reg     <= 1'b0;
            lock_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            retry_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            lock_reg      <= lock_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            retry_reg     <= retry_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        lock_next      = lock_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        retry_next     = retry_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    write_next = bus.cmd_write;
                    lock_next  = bus.cmd_lock;
                    addr_next  = bus.cmd_addr;
                    wdata_next = bus.cmd_wdata;
                    retry_next = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.HGRANT) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                state_next = bus.HGRANT ? ST_DATA : ST_REQ;
            end
            ST_DATA: begin
                // SPLIT takes effect even while the slave still holds HREADY low.
                if (bus.HRESP == RESP_SPLIT) begin
                    state_next = ST_REQ;
                end else if (bus.HREADY) begin
                    if (bus.HRESP == RESP_OKAY) begin
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = write_reg ? '0 : bus.HRDATA;
                        state_next     = ST_IDLE;
                    end else if (bus.HRESP == RESP_ERROR) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        retry_next = retry_inc;
                        if (retry_inc == CNT_W'(MAX_RETRY)) begin
                            rsp_valid_next = 1'b1;
                            rsp_err_next   = 1'b1;
                            state_next     = ST_IDLE;
                        end else begin
                            state_next = ST_ADDR;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.HREQ      = (state_reg != ST_IDLE);
    assign bus.HLOCK     = (state_reg != ST_IDLE) && lock_reg;
    assign bus.HTRANS    = (state_reg == ST_ADDR);
    assign bus.HADDR     = (state_reg == ST_ADDR || state_reg == ST_DATA) ? addr_reg : '0;
    assign bus.HWRITE    = (state_reg == ST_ADDR || state_reg == ST_DATA) && write_reg;
    assign bus.HWDATA    = (state_reg == ST_DATA && write_reg) ? wdata_reg : '0;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: a cycle-by-cycle vector table plus
// hand-written sequences for grant delay, wait states, RETRY, SPLIT, lock and reset.
module tb_bus_master_port;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    int   rsp_count = 0;

    bus_master_port_if #(.ADDR_W(16), .DATA_W(8)) bif ();

    bus_master_port #(.ADDR_W(16), .DATA_W(8), .MAX_RETRY(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (bif.rsp_valid === 1'b1) rsp_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cv, cw, cl;
        logic [15:0] ca;
        logic [7:0]  cd;
        logic        g, r;
        logic [1:0]  resp;
        logic [7:0]  rd;
        logic        e_rdy, e_req, e_lock, e_trans;
        logic [15:0] e_addr;
        logic        e_wr;
        logic [7:0]  e_wdata;
        logic        e_rv, e_err, e_rdchk;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic v, input logic w, input logic l,
                             input logic [15:0] a, input logic [7:0] d);
        bif.cmd_valid = v;
        bif.cmd_write = w;
        bif.cmd_lock  = l;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
    endtask

    task automatic drive_bus(input logic g, input logic r, input logic [1:0] resp,
                             input logic [7:0] rd);
        bif.HGRANT = g;
        bif.HREADY = r;
        bif.HRESP  = resp;
        bif.HRDATA = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, bif.cmd_ready, 0);
        chk({tag, "_hreq"},      bif.HREQ, 0);
        chk({tag, "_hlock"},     bif.HLOCK, 0);
        chk({tag, "_htrans"},    bif.HTRANS, 0);
        chk({tag, "_haddr"},     bif.HADDR, 0);
        chk({tag, "_hwrite"},    bif.HWRITE, 0);
        chk({tag, "_hwdata"},    bif.HWDATA, 0);
        chk({tag, "_rsp_valid"}, bif.rsp_valid, 0);
        chk({tag, "_rsp_err"},   bif.rsp_err, 0);
        chk({tag, "_rsp_rdata"}, bif.rsp_rdata, 0);
    endtask

    // Immediate grant, zero-wait response: completion expected 4 cycles after acceptance.
    task automatic run_simple(input string tag, input logic w, input logic [15:0] a,
                              input logic [7:0] d, input logic [1:0] resp,
                              input logic [7:0] hrd, input logic exp_err,
                              input logic [7:0] exp_rd);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        @(negedge CLK);
        drive_cmd(1'b1, w, 1'b0, a, d);
        drive_bus(1'b1, 1'b1, resp, hrd);
        chk({tag, "_ready"}, bif.cmd_ready, 1);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            bif.cmd_valid = 1'b0;
            lat++;
            if (bif.rsp_valid === 1'b1) begin
                seen = 1;
                chk({tag, "_latency"}, lat, 4);
                chk({tag, "_err"}, bif.rsp_err, exp_err);
                if (!w) chk({tag, "_rdata"}, bif.rsp_rdata, exp_rd);
            end
        end
        chk({tag, "_done"}, seen, 1);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        $display("txn %s: write=%0b addr=%04h latency=%0d err=%0b", tag, w, a, lat, bif.rsp_err);
    endtask

    initial begin
        int base;
        int addr_ph;
        bit seen;

        // cv cw cl  addr     wd     g  r  resp   rd    | rdy req lck trn addr     wr wdata  rv err rdchk rdata
        vecs[0]  = '{1'b1,1'b1,1'b0,16'h1234,8'hA5,1'b1,1'b1,2'b00,8'h00, 1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[1]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,2'b00,8'h00, 1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[2]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,2'b00,8'h00, 1'b0,1'b1,1'b0,1'b1,16'h1234,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,2'b00,8'h00, 1'b0,1'b1,1'b0,1'b0,16'h1234,1'b1,8'hA5,1'b0,1'b0,1'b0,8'h00};
        vecs[4]  = '{1'b1,1'b0,1'b1,16'h0042,8'hFF,1'b0,1'b1,2'b00,8'h00, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b1,1'b0,1'b0,8'h00};
        vecs[5]  = '{1'b1,1'b0,1'b1,16'h0042,8'hFF,1'b0,1'b1,2'b00,8'h00, 1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b1,2'b00,8'h00, 1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,2'b00,8'h00, 1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[8]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b0,2'b00,8'h00, 1'b0,1'b1,1'b1,1'b1,16'h0042,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[9]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b0,2'b00,8'h00, 1'b0,1'b1,1'b1,1'b0,16'h0042,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b1,1'b1,2'b00,8'h77, 1'b0,1'b1,1'b1,1'b0,16'h0042,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};
        vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,2'b00,8'h00, 1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b1,1'b0,1'b1,8'h77};
        vecs[12] = '{1'b0,1'b0,1'b0,16'h0000,8'h00,1'b0,1'b0,2'b00,8'h00, 1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00};

        // Reset state: outputs all zero while RST is held, cmd_ready right after release.
        RST = 1'b1;
        drive_cmd(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_release_ready", bif.cmd_ready, 1);

        // Write 0x1234/0xA5 with immediate grant, then a locked read that must wait for rsp_valid.
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge CLK);
            drive_cmd(vecs[i].cv, vecs[i].cw, vecs[i].cl, vecs[i].ca, vecs[i].cd);
            drive_bus(vecs[i].g, vecs[i].r, vecs[i].resp, vecs[i].rd);
            chk($sformatf("vec%0d_cmd_ready", i), bif.cmd_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_hreq", i),      bif.HREQ, vecs[i].e_req);
            chk($sformatf("vec%0d_hlock", i),     bif.HLOCK, vecs[i].e_lock);
            chk($sformatf("vec%0d_htrans", i),    bif.HTRANS, vecs[i].e_trans);
            chk($sformatf("vec%0d_haddr", i),     bif.HADDR, vecs[i].e_addr);
            chk($sformatf("vec%0d_hwrite", i),    bif.HWRITE, vecs[i].e_wr);
            chk($sformatf("vec%0d_hwdata", i),    bif.HWDATA, vecs[i].e_wdata);
            chk($sformatf("vec%0d_rsp_valid", i), bif.rsp_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("vec%0d_rsp_err", i), bif.rsp_err, vecs[i].e_err);
            if (vecs[i].e_rdchk) chk($sformatf("vec%0d_rsp_rdata", i), bif.rsp_rdata, vecs[i].e_rdata);
        end
        $display("txn table: write 1234/A5 then locked read 0042 -> 77");

        // Read with grant delayed 5 cycles and 2 wait states.
        @(negedge CLK);
        drive_cmd(1'b1, 1'b0, 1'b0, 16'h0BEE, 8'h00);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        chk("gd_ready", bif.cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bif.cmd_valid = 1'b0;
            chk($sformatf("gd_req_hold%0d", i), bif.HREQ, 1);
            chk($sformatf("gd_no_trans%0d", i), bif.HTRANS, 0);
        end
        @(negedge CLK);
        bif.HGRANT = 1'b1;
        chk("gd_trans_grant_cycle", bif.HTRANS, 0);
        @(negedge CLK);
        chk("gd_trans_after_grant", bif.HTRANS, 1);
        chk("gd_haddr", bif.HADDR, 16'h0BEE);
        @(negedge CLK);
        chk("gd_wait1_rsp", bif.rsp_valid, 0);
        @(negedge CLK);
        chk("gd_wait2_rsp", bif.rsp_valid, 0);
        @(negedge CLK);
        bif.HREADY = 1'b1;
        bif.HRDATA = 8'h3C;
        @(negedge CLK);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        chk("gd_rsp_valid", bif.rsp_valid, 1);
        chk("gd_rsp_rdata", bif.rsp_rdata, 8'h3C);
        chk("gd_rsp_err", bif.rsp_err, 0);
        $display("txn grant_delay: read 0BEE -> %02h", bif.rsp_rdata);

        // RETRY on every data phase: 4 address phases then an error completion.
        @(negedge CLK);
        drive_cmd(1'b1, 1'b1, 1'b0, 16'h0100, 8'h11);
        drive_bus(1'b1, 1'b1, 2'b10, 8'h00);
        addr_ph = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            bif.cmd_valid = 1'b0;
            if (bif.HTRANS === 1'b1) addr_ph++;
            if (bif.rsp_valid === 1'b1) begin
                seen = 1;
                chk("retry_err", bif.rsp_err, 1);
                chk("retry_hreq_low", bif.HREQ, 0);
            end
        end
        chk("retry_done", seen, 1);
        chk("retry_addr_phases", addr_ph, 4);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        $display("txn retry: write 0100 addr_phases=%0d", addr_ph);

        // SPLIT with HREADY low, grant withheld 3 cycles, then OKAY.
        @(negedge CLK);
        base = rsp_count;
        drive_cmd(1'b1, 1'b1, 1'b0, 16'h0200, 8'h5A);
        drive_bus(1'b1, 1'b1, 2'b00, 8'h00);
        @(negedge CLK);
        bif.cmd_valid = 1'b0;
        @(negedge CLK);
        chk("split_first_addr", bif.HTRANS, 1);
        @(negedge CLK);
        drive_bus(1'b0, 1'b0, 2'b11, 8'h00);
        chk("split_in_data", bif.HWDATA, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("split_hreq_hold%0d", i), bif.HREQ, 1);
            chk($sformatf("split_no_trans%0d", i), bif.HTRANS, 0);
        end
        @(negedge CLK);
        drive_bus(1'b1, 1'b1, 2'b00, 8'h00);
        chk("split_regrant_no_trans", bif.HTRANS, 0);
        @(negedge CLK);
        chk("split_second_addr", bif.HTRANS, 1);
        @(negedge CLK);
        chk("split_data_no_rsp", bif.rsp_valid, 0);
        @(negedge CLK);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        chk("split_rsp_valid", bif.rsp_valid, 1);
        chk("split_rsp_err", bif.rsp_err, 0);
        repeat (3) @(negedge CLK);
        chk("split_one_rsp", rsp_count - base, 1);
        $display("txn split: write 0200 responses=%0d", rsp_count - base);

        // Locked read, grant dropped in DATA, then reset mid-transfer.
        @(negedge CLK);
        base = rsp_count;
        drive_cmd(1'b1, 1'b0, 1'b1, 16'h0300, 8'h00);
        drive_bus(1'b1, 1'b0, 2'b00, 8'h00);
        @(negedge CLK);
        bif.cmd_valid = 1'b0;
        chk("lock_req", bif.HLOCK, 1);
        @(negedge CLK);
        chk("lock_addr", bif.HLOCK, 1);
        chk("lock_addr_trans", bif.HTRANS, 1);
        @(negedge CLK);
        bif.HGRANT = 1'b0;
        chk("lock_data", bif.HLOCK, 1);
        @(negedge CLK);
        chk("grant_drop_hreq", bif.HREQ, 1);
        chk("grant_drop_haddr", bif.HADDR, 16'h0300);
        chk("grant_drop_lock", bif.HLOCK, 1);
        RST = 1'b1;
        @(negedge CLK);
        chk_all_zero("midrst");
        RST = 1'b0;
        bif.HREADY = 1'b1;
        @(negedge CLK);
        chk("midrst_ready", bif.cmd_ready, 1);
        chk("midrst_hreq", bif.HREQ, 0);
        repeat (2) @(negedge CLK);
        chk("midrst_no_rsp", rsp_count - base, 0);
        drive_bus(1'b0, 1'b0, 2'b00, 8'h00);
        $display("txn lock_reset: read 0300 discarded, responses=%0d", rsp_count - base);

        run_simple("error_write", 1'b1, 16'h0400, 8'hC3, 2'b01, 8'h00, 1'b1, 8'h00);
        run_simple("okay_read", 1'b0, 16'h0500, 8'h00, 2'b00, 8'h96, 1'b0, 8'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
